// File: rtl/ones_detector_pkg.sv
// ones_detector_pkg
// Shared constants and helper functions for the ones_detector block.
//   - DATA_W / CNT_W        : analysed word width and bit-count width
//   - *_BIT / CNT_LSB/MSB   : bit positions of the fields in the status word
//   - BAL_THRESH            : count at which a word is considered balanced
//   - odd_parity()          : odd-parity flag derived from a bit count
//   - build_status()        : assembles the full status word from one count
package ones_detector_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam int CNT_LSB  = 0;
  localparam int CNT_MSB  = 3;
  localparam int BAL_BIT  = 4;
  localparam int PAR_BIT  = 5;
  localparam int ALL1_BIT = 6;
  localparam int ALL0_BIT = 7;

  localparam logic [CNT_W-1:0] BAL_THRESH = 4'd4;
  localparam logic [CNT_W-1:0] CNT_MAX    = 4'd8;
  localparam logic [CNT_W-1:0] CNT_MIN    = 4'd0;

  // The count is odd exactly when its LSB is set.
  function automatic logic odd_parity(input logic [CNT_W-1:0] cnt);
    return cnt[0];
  endfunction

  // Every flag comes from the same count so the word is self-consistent.
  function automatic logic [DATA_W-1:0] build_status(input logic [CNT_W-1:0] cnt);
    logic [DATA_W-1:0] s;
    s                   = {DATA_W{1'b0}};
    s[CNT_MSB:CNT_LSB]  = cnt;
    s[BAL_BIT]          = (cnt == BAL_THRESH);
    s[PAR_BIT]          = odd_parity(cnt);
    s[ALL1_BIT]         = (cnt == CNT_MAX);
    s[ALL0_BIT]         = (cnt == CNT_MIN);
    return s;
  endfunction

endpackage

// File: rtl/ones_detector_popcount8.sv
// popcount8
// Purely combinational population count of an 8-bit word, built as a
// three-level adder tree (pairs -> quads -> full word).
// Ports:
//   data_i  [7:0] : word to count
//   count_o [3:0] : number of set bits, 0..8 (8 encodes as 4'b1000)
module popcount8
  import ones_detector_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o
);

  logic [1:0] pair_s [4];
  logic [2:0] quad_s [2];

  // Adder tree: widths grow by one bit per level so nothing can wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pair_s[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
    end
    for (int j = 0; j < 2; j++) begin
      quad_s[j] = {1'b0, pair_s[2*j]} + {1'b0, pair_s[2*j+1]};
    end
    count_o = {1'b0, quad_s[0]} + {1'b0, quad_s[1]};
  end

endmodule

// File: rtl/ones_detector.sv
// ones_detector
// Counts the set bits of an 8-bit word every cycle and reports the count
// plus balanced / odd-parity / all-ones / all-zeros flags in a registered
// status word.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low; clears all state immediately
//   in   [7:0] : word to analyse, sampled every rising edge
//   out  [7:0] : {all0, all1, odd, balanced, count[3:0]}, driven from flops
// Configuration:
//   ONES_DETECTOR_PIPE_EN : when defined, an input register is placed in
//                           front of the count logic (latency 2 instead of 1).
module ones_detector
  import ones_detector_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] cnt_in_s;
  logic [CNT_W-1:0]  cnt_s;
  logic [DATA_W-1:0] status_d;
  logic [DATA_W-1:0] status_q;

`ifdef ONES_DETECTOR_PIPE_EN
  logic [DATA_W-1:0] in_d;
  logic [DATA_W-1:0] in_q;

  // Next value of the input stage is simply the current input word.
  always_comb begin
    in_d = in;
  end

  // Input stage register; clears with reset so no stale word survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q <= {DATA_W{1'b0}};
    end else begin
      in_q <= in_d;
    end
  end

  assign cnt_in_s = in_q;
`else
  assign cnt_in_s = in;
`endif

  popcount8 u_popcount8 (
    .data_i  (cnt_in_s),
    .count_o (cnt_s)
  );

  // Status word assembled from a single count so all fields agree.
  always_comb begin
    status_d = build_status(cnt_s);
  end

  // Output register; out has no combinational path from in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= {DATA_W{1'b0}};
    end else begin
      status_q <= status_d;
    end
  end

  assign out = status_q;

endmodule

// File: tb/tb_ones_detector.sv
// tb_ones_detector
// Self-checking bench for ones_detector: directed scenarios, mid-stream
// reset, random words and a full 256-value sweep, all compared against a
// behavioural reference model kept in the bench.
module tb_ones_detector;

`ifdef ONES_DETECTOR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_s;
  logic [7:0] out_s;

  int checks;
  int errors;

  // Reference model state: expected output and the word held in the
  // optional input stage (only meaningful when LAT == 2).
  logic [7:0] exp_out;
  logic [7:0] exp_stage;

  ones_detector dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_s),
    .out   (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference status word computed straight from the field definitions.
  function automatic logic [7:0] ref_status(input logic [7:0] v);
    int cnt;
    int s;
    cnt = 0;
    for (int b = 0; b < 8; b++) cnt = cnt + ((v >> b) & 1);
    s = cnt;
    if (cnt == 4) s = s + 16;
    if ((cnt % 2) == 1) s = s + 32;
    if (cnt == 8) s = s + 64;
    if (cnt == 0) s = s + 128;
    return s[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_out   = 8'h00;
    exp_stage = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] v);
    if (LAT == 2) begin
      exp_out   = ref_status(exp_stage);
      exp_stage = v;
    end else begin
      exp_out = ref_status(v);
    end
  endtask

  // Drive one word before an edge, advance the model, check after the edge.
  task automatic step(input logic [7:0] v, input string tag);
    @(negedge clk);
    in_s = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check(tag, out_s, exp_out);
  endtask

  // Hold a word long enough to traverse the pipe, then compare to a constant.
  task automatic hold_expect(input logic [7:0] v, input logic [7:0] lit, input string tag);
    for (int k = 0; k < LAT; k++) step(v, tag);
    check({tag, "_lit"}, out_s, lit);
  endtask

  // Structural consistency of the flags against the reported count.
  task automatic check_fields(input logic [7:0] v);
    int cnt;
    cnt = 0;
    for (int b = 0; b < 8; b++) cnt = cnt + ((v >> b) & 1);
    check("sweep_cnt", {4'h0, out_s[3:0]}, cnt[7:0]);
    check("sweep_flags", {4'h0, out_s[7:4]},
          {4'h0, (cnt == 0) ? 1'b1 : 1'b0, (cnt == 8) ? 1'b1 : 1'b0,
           cnt[0], (cnt == 4) ? 1'b1 : 1'b0});
    check("sweep_excl", {6'h00, out_s[6] & out_s[7], out_s[4] & out_s[6]}, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_s   = 8'hFF;
    reset  = 1'b0;
    model_reset();

    // Reset held for 5 cycles with all-ones input: out stays zero.
    #1;
    check("reset_initial", out_s, 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("reset_hold", out_s, 8'h00);
    end

    // Release between edges; first edge captures normally.
    @(negedge clk);
    reset = 1'b1;
    hold_expect(8'b10101010, 8'h14, "balanced");
    hold_expect(8'b00011000, 8'h02, "count2");
    hold_expect(8'b00101001, 8'h23, "count3_odd");
    hold_expect(8'hFF, 8'h48, "all_ones");
    hold_expect(8'h00, 8'h80, "all_zeros");

    // Asynchronous clear between edges, no clock needed.
    step(8'h0F, "pre_async");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", out_s, 8'h00);
    model_reset();

    // Mid-stream reset with data in flight: nothing stale after release.
    @(negedge clk);
    reset = 1'b1;
    step(8'h7F, "stream_a");
    step(8'h01, "stream_b");
    @(negedge clk);
    in_s  = 8'hEE;
    reset = 1'b0;
    #1;
    check("midstream_clear", out_s, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    check("midstream_hold", out_s, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    step(8'h03, "post_release_1");
    step(8'hC0, "post_release_2");

    // Constant input keeps output constant.
    for (int c = 0; c < 4; c++) step(8'h5A, "const_hold");

    // Random words against the model.
    for (int r = 0; r < 200; r++) step($urandom_range(255, 0), "random");

    // Exhaustive sweep; once the pipe is full every output is checked field by field.
    for (int v = 0; v < 256 + LAT - 1; v++) begin
      step(v[7:0], "sweep");
      if (v >= LAT - 1) check_fields(v - (LAT - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
